// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO sizing constants and types
package fifo_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int ADDR_W        = $clog2(DEFAULT_DEPTH);
    localparam int PTR_W         = ADDR_W + 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [PTR_W-1:0]  ptr_t;

endpackage

// File: rtl/fifo_control_unit_if.sv
// rtl/fifo_control_unit_if.sv - request, register-file and status signals of the FIFO controller
interface fifo_control_unit_if
    import fifo_pkg::*;
#(
    parameter int AW = ADDR_W
);
    logic          push;
    logic          pop;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;
    logic          we;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    modport master (
        output push, pop,
        input  w_addr, r_addr, we, full, empty, count,
        input  almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  push, pop,
        output w_addr, r_addr, we, full, empty, count,
        output almost_full, almost_empty, overflow, underflow
    );

endinterface

// File: rtl/fifo_control_unit.sv
// rtl/fifo_control_unit.sv - FIFO pointer/flag controller driving a dual-port register file
module fifo_control_unit
    import fifo_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_control_unit_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

    logic [PW-1:0] w_ptr;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] occ;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          pop_ok;
    logic          overflow_q;
    logic          underflow_q;

    // Status comes only from registered pointers, so push/pop never reach the flags.
    assign empty = (w_ptr == r_ptr);
    assign full  = (w_ptr[AW-1:0] == r_ptr[AW-1:0]) && (w_ptr[AW] != r_ptr[AW]);
    assign occ   = w_ptr - r_ptr;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok = bus.push && (!full || bus.pop);
    assign pop_ok  = bus.pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_ptr       <= '0;
            r_ptr       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                w_ptr <= w_ptr + PW'(1);
            end
            if (pop_ok) begin
                r_ptr <= r_ptr + PW'(1);
            end
            if (bus.push && full && !bus.pop) begin
                overflow_q <= 1'b1;
            end
            if (bus.pop && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.we           = push_ok && rst_n;
    assign bus.w_addr       = w_ptr[AW-1:0];
    assign bus.r_addr       = r_ptr[AW-1:0];
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.count        = occ;
    assign bus.almost_full  = (occ >= AF_L);
    assign bus.almost_empty = (occ <= AE_L);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_control_unit.sv
// tb/tb_fifo_control_unit.sv - scoreboard bench for fifo_control_unit with a queue-based reference
module tb_fifo_control_unit;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] wdata;
    logic [7:0] mem [DEPTH];
    logic [7:0] pop_data;

    fifo_control_unit_if #(.AW(2)) bus ();

    fifo_control_unit #(.DEPTH(DEPTH), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Storage array the controller addresses; read is combinational.
    always @(posedge clk) begin
        if (bus.we) mem[bus.w_addr] <= wdata;
    end
    assign pop_data = mem[bus.r_addr];

    typedef struct {
        int we, w_addr, r_addr, count;
        int full, empty, af, ae, ovf, unf;
        int chk_data, data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mq[$];
    int         m_wa = 0;
    int         m_ra = 0;
    int         m_ovf = 0;
    int         m_unf = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic pu, input logic po, input logic [7:0] d);
        exp_t e;
        int   sz;
        @(posedge clk);
        #1;
        rst_n    = r;
        bus.push = pu;
        bus.pop  = po;
        wdata    = d;
        sz = mq.size();
        e.we       = (r && pu && (sz < DEPTH || po)) ? 1 : 0;
        e.w_addr   = m_wa;
        e.r_addr   = m_ra;
        e.count    = sz;
        e.full     = (sz == DEPTH) ? 1 : 0;
        e.empty    = (sz == 0) ? 1 : 0;
        e.af       = (sz >= 3) ? 1 : 0;
        e.ae       = (sz <= 1) ? 1 : 0;
        e.ovf      = m_ovf;
        e.unf      = m_unf;
        e.chk_data = (r && po && sz > 0) ? 1 : 0;
        e.data     = (sz > 0) ? int'(mq[0]) : 0;
        exp_q.push_back(e);
        if (!r) begin
            mq.delete();
            m_wa = 0; m_ra = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (pu && sz == DEPTH && !po) m_ovf = 1;
            if (po && sz == 0) m_unf = 1;
            if (po && sz > 0) begin
                void'(mq.pop_front());
                m_ra = (m_ra + 1) % DEPTH;
            end
            if (e.we == 1) begin
                mq.push_back(d);
                m_wa = (m_wa + 1) % DEPTH;
            end
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("we",           int'(bus.we),           mon_e.we);
            check("w_addr",       int'(bus.w_addr),       mon_e.w_addr);
            check("r_addr",       int'(bus.r_addr),       mon_e.r_addr);
            check("count",        int'(bus.count),        mon_e.count);
            check("full",         int'(bus.full),         mon_e.full);
            check("empty",        int'(bus.empty),        mon_e.empty);
            check("almost_full",  int'(bus.almost_full),  mon_e.af);
            check("almost_empty", int'(bus.almost_empty), mon_e.ae);
            check("overflow",     int'(bus.overflow),     mon_e.ovf);
            check("underflow",    int'(bus.underflow),    mon_e.unf);
            if (mon_e.chk_data == 1) check("pop_data", int'(pop_data), mon_e.data);
        end
    end

    initial begin
        rst_n    = 1'b0;
        bus.push = 1'b1;
        bus.pop  = 1'b0;
        wdata    = 8'h00;
        @(posedge clk);

        repeat (2) cycle(1'b0, 1'b1, 1'b0, 8'hFF);

        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 8'(8'hA1 + i));
        cycle(1'b1, 1'b1, 1'b0, 8'hA5);

        repeat (5) cycle(1'b1, 1'b0, 1'b1, 8'h00);

        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'(8'hB0 + i));
            cycle(1'b1, 1'b0, 1'b1, 8'h00);
        end

        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
        cycle(1'b1, 1'b1, 1'b1, 8'hC4);
        cycle(1'b1, 1'b1, 1'b1, 8'hC5);
        repeat (4) cycle(1'b1, 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b1, 1'b1, 8'hD0);
        cycle(1'b1, 1'b0, 1'b1, 8'h00);

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 8'(8'hE0 + i));
        cycle(1'b1, 1'b1, 1'b1, 8'hE3);
        cycle(1'b0, 1'b1, 1'b1, 8'hEE);
        cycle(1'b1, 1'b1, 1'b0, 8'hF0);
        cycle(1'b1, 1'b0, 1'b1, 8'h00);

        repeat (1500) begin
            cycle(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 8'($urandom));
        end
        cycle(1'b1, 1'b0, 1'b0, 8'h00);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_control_unit.md
# fifo_control_unit

Pointer and flag controller that pairs with the team's dual-port FIFO register file. It converts producer `push` / consumer `pop` requests into `w_addr`, `r_addr` and `we` for the storage array. It also maintains occupancy, full/empty and almost-full/almost-empty status, plus sticky overflow/underflow error flags. A thin top `fifo` instantiates this block next to the register file; data never passes through this block.

## Interface
- `DEPTH`, 4: number of words; must be a power of two, ≥ 2.
- `AF_LEVEL`, DEPTH-1: `almost_full` asserts when `count >= AF_LEVEL`.
- `AE_LEVEL`, 1: `almost_empty` asserts when `count <= AE_LEVEL`.
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `push`, in, 1: producer write request for the current cycle.
- `pop`, in, 1: consumer read request for the current cycle.
- `w_addr`, out, $clog2(DEPTH): write address to the register file.
- `r_addr`, out, $clog2(DEPTH): read address to the register file.
- `we`, out, 1: write enable to the register file (combinational).
- `full`, out, 1: FIFO holds DEPTH words.
- `empty`, out, 1: FIFO holds 0 words.
- `count`, out, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `almost_full`, out, 1: occupancy threshold flag, as defined under `AF_LEVEL`.
- `almost_empty`, out, 1: occupancy threshold flag, as defined under `AE_LEVEL`.
- `overflow`, out, 1: sticky; set when a push is rejected.
- `underflow`, out, 1: sticky; set when a pop is rejected.

## Operation
- **Pointers.** `w_ptr` and `r_ptr` are each $clog2(DEPTH)+1 bits: an address field plus one wrap bit.
  - `w_addr` and `r_addr` are the low $clog2(DEPTH) bits of the respective pointer.
  - Address wraps DEPTH-1 → 0 and the wrap bit toggles.
- **Status decode**, from registered pointers only:
  - `empty` = (`w_ptr` == `r_ptr`).
  - `full` = address fields equal and wrap bits differ.
  - `count` = `w_ptr` − `r_ptr`, modulo 2^($clog2(DEPTH)+1).
- **Accept rules**, evaluated each cycle:
  - `push_ok` = `push` & (!`full` | `pop`).
  - `pop_ok` = `pop` & !`empty`.
  - `we` = `push_ok`.
- **Pointer update.** On `push_ok`, `w_ptr` increments; on `pop_ok`, `r_ptr` increments. Both may increment in the same cycle.
- **Simultaneous events:**
  - Full with push & pop: both accepted. `count` stays DEPTH and `full` stays 1. The word at `r_addr` is consumed combinationally before the edge that overwrites it.
  - Empty with push & pop: the push is accepted, the pop is rejected, and `underflow` is set. Next cycle `count` = 1.
  - Neither full nor empty: both accepted; `count` unchanged.
- **Errors:**
  - `overflow` sets on `push` & `full` & !`pop`.
  - `underflow` sets on `pop` & `empty`.
  - Both flags clear only on reset.
- **Reset** (`rst_n` = 0 at a rising edge): both pointers go to 0, and both error flags go to 0.
  - Resulting outputs: `empty` = 1, `full` = 0, `count` = 0, `almost_empty` = 1, `almost_full` = 0, `w_addr` = `r_addr` = 0.
  - Reset mid-operation discards all contents and overrides any `push`/`pop` in the same cycle.
  - `we` is forced to 0 while `rst_n` = 0.

## Timing
- Zero-latency request path: `we` and `w_addr` are valid in the same cycle as `push`. The register file writes at that rising edge.
- Read data (`pop_data`) is combinational from `r_addr`. It is valid whenever `empty` = 0, so the consumer samples it in the cycle it asserts `pop`.
- `full`, `empty`, `count` and the almost flags change one cycle after the accepting edge, and are registered-derived.
  - No combinational path from `push`/`pop` to these flags.
- A word pushed at edge N is first visible on `pop_data` after edge N: the cycle following the push.
- `overflow` and `underflow` assert the cycle after the offending edge.

## Structure
- Shared package or header `fifo_pkg`:
  - `DEPTH` default.
  - Width constants `ADDR_W` = $clog2(DEPTH) and `PTR_W` = `ADDR_W`+1.
- No sub-module: pointer logic is two counters plus a decode.
- Top `fifo` wires `fifo_control_unit` to the register file. Shared signals: `w_addr`, `r_addr`, `we`, `clk`.

## Test plan
All scenarios use DEPTH = 4, AF_LEVEL = 3, AE_LEVEL = 1.
- **Reset:** hold `rst_n` = 0 with `push` = 1 for 2 cycles → `we` = 0, `count` = 0, `empty` = 1, `full` = 0, error flags 0, addresses 0.
- **Fill then overflow:** push 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles → `w_addr` 0, 1, 2, 3; `count` 1, 2, 3, 4; `almost_full` at `count` 3; `full` = 1. Fifth push (no pop) → `we` = 0, `overflow` = 1, `count` stays 4.
- **Drain then underflow:** pop 4× → `pop_data` 0xA1..0xA4 in order, `r_addr` 0..3, `empty` = 1 after the fourth pop. Extra pop → `underflow` = 1, `r_addr` stays 0.
- **Wrap-around:** push 6 and pop 6 interleaved, one at a time → addresses go 0, 1, 2, 3, 0, 1; data order preserved; `count` never exceeds 1.
- **Simultaneous events:**
  - Push & pop while full → `we` = 1, `count` stays 4, the popped word equals the oldest entry.
  - Push & pop while empty → `count` = 1 next cycle, `underflow` = 1.
- **Reset mid-operation:** with `count` = 3, apply reset for one cycle → `count` = 0, `empty` = 1, `overflow`/`underflow` cleared. Next push writes `w_addr` 0.
